// File: rtl/boot_ctrl_pkg.sv
// Shared types and helpers for the boot loader controller: FSM states,
// write-mask constants and the fill-count to byte-lane mask mapping.
package boot_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_FULL = 4'b1111;

  // Lanes are filled from byte 0 upward, so a partial word covers the low lanes.
  function automatic logic [3:0] fill_to_mask(input logic [2:0] fill);
    logic [3:0] mask;
    case (fill)
      3'd1:    mask = 4'b0001;
      3'd2:    mask = 4'b0011;
      3'd3:    mask = 4'b0111;
      3'd4:    mask = MASK_FULL;
      default: mask = MASK_NONE;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/boot_loader_ctrl_byte_packer.sv
// Assembles the incoming byte stream into little-endian 32-bit words; the
// owning FSM clears it after each flush and on load entry.
module byte_packer
  import boot_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  output logic [31:0] word,
  output logic [3:0]  mask,
  output logic        word_ready,
  output logic        last
);

  logic [31:0] word_r;
  logic [2:0]  fill_r;
  logic        last_r;

  // Lane assembly; unfilled lanes stay zero so partial words need no masking
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      word_r <= 32'h0000_0000;
      fill_r <= 3'd0;
      last_r <= 1'b0;
    end else if (accept) begin
      word_r[{fill_r[1:0], 3'b000} +: 8] <= byte_data;
      fill_r <= fill_r + 3'd1;
      last_r <= byte_last;
    end
  end

  assign word_ready = accept && ((fill_r == 3'd3) || byte_last);
  assign word       = word_r;
  assign mask       = fill_to_mask(fill_r);
  assign last       = last_r;

endmodule

// File: rtl/boot_loader_ctrl.sv
// Boot loader controller: streams an image into shared memory with the core
// held in reset, then runs the core until halt. Optional checksum: LOADER_CHECKSUM_EN.
module boot_loader_ctrl
  import boot_ctrl_pkg::*;
#(
  parameter int          NUM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  output logic        byte_ready,
  output logic        cpu_reset,
  input  logic [31:0] cpu_Address,
  input  logic [31:0] cpu_WriteData,
  input  logic        cpu_MemWrite,
  input  logic [3:0]  cpu_WriteMask,
  input  logic        cpu_halt,
  output logic [31:0] mem_Address,
  output logic [31:0] mem_WriteData,
  output logic        mem_MemWrite,
  output logic [3:0]  mem_WriteMask,
  output logic        busy,
  output logic        done,
  output logic [15:0] word_count,
  output logic [31:0] cycle_count,
  output logic        err_overflow,
  output logic [31:0] checksum
);

  localparam logic [15:0] NUM_WORDS_W = 16'(NUM_WORDS);

  state_e      state_r, next_s;
  logic        accept_s, load_entry_s, overflow_s, clear_s;
  logic [31:0] pk_word_s, flush_addr_s;
  logic [3:0]  pk_mask_s;
  logic        pk_ready_s, pk_last_s;
  logic [15:0] word_count_r;
  logic [31:0] cycle_count_r, addr_hold_r;
  logic        err_overflow_r;

  assign accept_s     = byte_valid && byte_ready;
  assign load_entry_s = ((state_r == IDLE) || (state_r == DONE)) && start;
  assign overflow_s   = (word_count_r == NUM_WORDS_W);
  assign flush_addr_s = BASE_ADDR + {14'd0, word_count_r, 2'b00};
  assign clear_s      = load_entry_s || (state_r == FLUSH);

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear_s),
    .accept     (accept_s),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .word       (pk_word_s),
    .mask       (pk_mask_s),
    .word_ready (pk_ready_s),
    .last       (pk_last_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= next_s;
  end

  // Next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE, DONE: if (start) next_s = LOAD; else next_s = state_r;
      LOAD:       if (pk_ready_s) next_s = FLUSH; else next_s = LOAD;
      FLUSH:      if (pk_last_s) next_s = RUN; else next_s = LOAD;
      RUN:        if (cpu_halt) next_s = DONE; else next_s = RUN;
      default:    next_s = IDLE;
    endcase
  end

  // Output decode; in RUN the core owns the memory port with no added latency
  always_comb begin
    byte_ready    = 1'b0;
    cpu_reset     = 1'b1;
    busy          = 1'b0;
    done          = 1'b0;
    mem_Address   = addr_hold_r;
    mem_WriteData = 32'h0000_0000;
    mem_MemWrite  = 1'b0;
    mem_WriteMask = MASK_NONE;
    case (state_r)
      IDLE: done = 1'b0;
      LOAD: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      FLUSH: begin
        busy          = 1'b1;
        mem_Address   = flush_addr_s;
        mem_WriteData = pk_word_s;
        if (overflow_s) begin
          mem_MemWrite  = 1'b0;
          mem_WriteMask = MASK_NONE;
        end else begin
          mem_MemWrite  = 1'b1;
          mem_WriteMask = pk_mask_s;
        end
      end
      RUN: begin
        busy          = 1'b1;
        cpu_reset     = 1'b0;
        mem_Address   = cpu_Address;
        mem_WriteData = cpu_WriteData;
        mem_MemWrite  = cpu_MemWrite;
        mem_WriteMask = cpu_WriteMask;
      end
      DONE:    done = 1'b1;
      default: done = 1'b0;
    endcase
  end

  // Load/run counters and sticky overflow; the halt cycle itself is not counted
  always_ff @(posedge clk) begin
    if (!reset) begin
      word_count_r   <= 16'd0;
      cycle_count_r  <= 32'd0;
      err_overflow_r <= 1'b0;
    end else if (load_entry_s) begin
      word_count_r   <= 16'd0;
      cycle_count_r  <= 32'd0;
      err_overflow_r <= 1'b0;
    end else begin
      if (state_r == FLUSH) begin
        if (overflow_s) err_overflow_r <= 1'b1;
        else            word_count_r   <= word_count_r + 16'd1;
      end
      if ((state_r == RUN) && !cpu_halt) cycle_count_r <= cycle_count_r + 32'd1;
    end
  end

  // Memory address holds its last driven value outside FLUSH/RUN
  always_ff @(posedge clk) begin
    if (!reset) addr_hold_r <= 32'h0000_0000;
    else        addr_hold_r <= mem_Address;
  end

  assign word_count   = word_count_r;
  assign cycle_count  = cycle_count_r;
  assign err_overflow = err_overflow_r;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum_r;

  // Wrap-around sum of committed words only
  always_ff @(posedge clk) begin
    if (!reset)                                checksum_r <= 32'h0000_0000;
    else if (load_entry_s)                     checksum_r <= 32'h0000_0000;
    else if ((state_r == FLUSH) && !overflow_s) checksum_r <= checksum_r + pk_word_s;
  end

  assign checksum = checksum_r;
`else
  assign checksum = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed self-checking bench for boot_loader_ctrl (NUM_WORDS=2 so the
// overflow path is reachable with a short image).
module tb_boot_loader_ctrl;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic        byte_valid = 1'b0, byte_last = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic [31:0] cpu_Address = 32'h0, cpu_WriteData = 32'h0;
  logic        cpu_MemWrite = 1'b0, cpu_halt = 1'b0;
  logic [3:0]  cpu_WriteMask = 4'h0;
  logic        byte_ready, cpu_reset, mem_MemWrite, busy, done, err_overflow;
  logic [31:0] mem_Address, mem_WriteData, cycle_count, checksum;
  logic [3:0]  mem_WriteMask;
  logic [15:0] word_count;

  boot_loader_ctrl #(.NUM_WORDS(2), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_last(byte_last), .byte_ready(byte_ready),
    .cpu_reset(cpu_reset), .cpu_Address(cpu_Address), .cpu_WriteData(cpu_WriteData),
    .cpu_MemWrite(cpu_MemWrite), .cpu_WriteMask(cpu_WriteMask), .cpu_halt(cpu_halt),
    .mem_Address(mem_Address), .mem_WriteData(mem_WriteData),
    .mem_MemWrite(mem_MemWrite), .mem_WriteMask(mem_WriteMask), .busy(busy),
    .done(done), .word_count(word_count), .cycle_count(cycle_count),
    .err_overflow(err_overflow), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic [31:0] log_addr [0:63];
  logic [31:0] log_data [0:63];
  logic [3:0]  log_mask [0:63];
  int          wr_total = 0;
  logic [7:0]  img [0:15];

  // Memory-side write log, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_MemWrite === 1'b1 && wr_total < 64) begin
      log_addr[wr_total] <= mem_Address;
      log_data[wr_total] <= mem_WriteData;
      log_mask[wr_total] <= mem_WriteMask;
      wr_total <= wr_total + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    byte_valid = 1'b1; byte_data = d; byte_last = l;
    while (byte_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL byte_ready_timeout got=%b exp=1", byte_ready); end
    tick();
    byte_valid = 1'b0; byte_last = 1'b0;
  endtask

  task automatic load_bytes(input int n);
    for (int i = 0; i < n; i++) send_byte(img[i], (i == n - 1));
  endtask

  task automatic test_reset();
    reset = 1'b0; tick(); tick(); reset = 1'b1;
    checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset got=%b exp=1", cpu_reset); end
    checks++; if ({byte_ready, busy, done, err_overflow} !== 4'b0000) begin errors++; $display("FAIL rst_flags got=%b exp=0000", {byte_ready, busy, done, err_overflow}); end
    checks++; if (word_count !== 16'd0 || cycle_count !== 32'd0) begin errors++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", word_count, cycle_count); end
    checks++; if (mem_MemWrite !== 1'b0 || mem_WriteMask !== 4'h0) begin errors++; $display("FAIL rst_mem got=%b/%h exp=0/0", mem_MemWrite, mem_WriteMask); end
    checks++; if (checksum !== 32'h0) begin errors++; $display("FAIL rst_checksum got=%h exp=0", checksum); end
  endtask

  task automatic test_full_load_run();
    int base;
    base = wr_total;
    img[0] = 8'h13; img[1] = 8'h05; img[2] = 8'h00; img[3] = 8'h00;
    img[4] = 8'h73; img[5] = 8'h00; img[6] = 8'h10; img[7] = 8'h00;
    pulse_start();
    load_bytes(8);
    tick();
    checks++; if (wr_total - base !== 2) begin errors++; $display("FAIL full_wr_count got=%0d exp=2", wr_total - base); end
    checks++; if (log_addr[base] !== 32'h0 || log_data[base] !== 32'h0000_0513 || log_mask[base] !== 4'hf) begin errors++; $display("FAIL full_wr0 got=%h/%h/%h exp=0/00000513/f", log_addr[base], log_data[base], log_mask[base]); end
    checks++; if (log_addr[base+1] !== 32'h4 || log_data[base+1] !== 32'h0010_0073 || log_mask[base+1] !== 4'hf) begin errors++; $display("FAIL full_wr1 got=%h/%h/%h exp=4/00100073/f", log_addr[base+1], log_data[base+1], log_mask[base+1]); end
    checks++; if (word_count !== 16'd2) begin errors++; $display("FAIL full_word_count got=%0d exp=2", word_count); end
    checks++; if (cpu_reset !== 1'b0 || busy !== 1'b1 || cycle_count !== 32'd0) begin errors++; $display("FAIL full_run_entry got=%b/%b/%0d exp=0/1/0", cpu_reset, busy, cycle_count); end
    for (int i = 0; i < 5; i++) tick();
    cpu_halt = 1'b1; tick(); cpu_halt = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || cpu_reset !== 1'b1) begin errors++; $display("FAIL full_done got=%b/%b/%b exp=1/0/1", done, busy, cpu_reset); end
    tick();
    checks++; if (cycle_count !== 32'd5) begin errors++; $display("FAIL full_cycle_count got=%0d exp=5", cycle_count); end
`ifdef LOADER_CHECKSUM_EN
    checks++; if (checksum !== 32'h0010_0586) begin errors++; $display("FAIL full_checksum got=%h exp=00100586", checksum); end
`else
    checks++; if (checksum !== 32'h0) begin errors++; $display("FAIL full_checksum got=%h exp=0", checksum); end
`endif
  endtask

  task automatic test_partial_word();
    int base;
    base = wr_total;
    img[0] = 8'hAA; img[1] = 8'hBB; img[2] = 8'hCC; img[3] = 8'hDD;
    img[4] = 8'h11; img[5] = 8'h22;
    pulse_start();
    checks++; if (cycle_count !== 32'd0 || word_count !== 16'd0 || byte_ready !== 1'b1) begin errors++; $display("FAIL part_load_entry got=%0d/%0d/%b exp=0/0/1", cycle_count, word_count, byte_ready); end
    load_bytes(6);
    tick();
    checks++; if (wr_total - base !== 2) begin errors++; $display("FAIL part_wr_count got=%0d exp=2", wr_total - base); end
    checks++; if (log_data[base] !== 32'hDDCC_BBAA || log_mask[base] !== 4'hf) begin errors++; $display("FAIL part_wr0 got=%h/%h exp=ddccbbaa/f", log_data[base], log_mask[base]); end
    checks++; if (log_addr[base+1] !== 32'h4 || log_data[base+1] !== 32'h0000_2211 || log_mask[base+1] !== 4'b0011) begin errors++; $display("FAIL part_wr1 got=%h/%h/%h exp=4/00002211/3", log_addr[base+1], log_data[base+1], log_mask[base+1]); end
    checks++; if (word_count !== 16'd2 || err_overflow !== 1'b0) begin errors++; $display("FAIL part_counts got=%0d/%b exp=2/0", word_count, err_overflow); end
    cpu_halt = 1'b1; tick(); cpu_halt = 1'b0;
  endtask

  task automatic test_overflow();
    int base;
    base = wr_total;
    for (int i = 0; i < 12; i++) img[i] = 8'(i + 1);
    pulse_start();
    load_bytes(12);
    tick();
    checks++; if (wr_total - base !== 2) begin errors++; $display("FAIL ovf_wr_count got=%0d exp=2", wr_total - base); end
    checks++; if (log_data[base] !== 32'h0403_0201 || log_data[base+1] !== 32'h0807_0605) begin errors++; $display("FAIL ovf_data got=%h/%h exp=04030201/08070605", log_data[base], log_data[base+1]); end
    checks++; if (err_overflow !== 1'b1 || word_count !== 16'd2) begin errors++; $display("FAIL ovf_flags got=%b/%0d exp=1/2", err_overflow, word_count); end
    checks++; if (busy !== 1'b1 || cpu_reset !== 1'b0) begin errors++; $display("FAIL ovf_run got=%b/%b exp=1/0", busy, cpu_reset); end
  endtask

  task automatic test_run_mux();
    cpu_Address = 32'h100; cpu_WriteData = 32'hDEAD_BEEF; cpu_MemWrite = 1'b1; cpu_WriteMask = 4'b0100;
    #1;
    checks++; if (mem_Address !== 32'h100 || mem_WriteData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mux_addr_data got=%h/%h exp=100/deadbeef", mem_Address, mem_WriteData); end
    checks++; if (mem_MemWrite !== 1'b1 || mem_WriteMask !== 4'b0100) begin errors++; $display("FAIL mux_strobe got=%b/%h exp=1/4", mem_MemWrite, mem_WriteMask); end
    pulse_start();
    checks++; if (busy !== 1'b1 || cpu_reset !== 1'b0 || cycle_count !== 32'd1) begin errors++; $display("FAIL mux_start_ignored got=%b/%b/%0d exp=1/0/1", busy, cpu_reset, cycle_count); end
    cpu_halt = 1'b1; tick(); cpu_halt = 1'b0;
    checks++; if (done !== 1'b1 || cycle_count !== 32'd1) begin errors++; $display("FAIL mux_halt got=%b/%0d exp=1/1", done, cycle_count); end
    checks++; if (mem_MemWrite !== 1'b0 || mem_WriteMask !== 4'h0) begin errors++; $display("FAIL mux_done_gate got=%b/%h exp=0/0", mem_MemWrite, mem_WriteMask); end
    cpu_Address = 32'h200; #1;
    checks++; if (mem_Address !== 32'h100) begin errors++; $display("FAIL mux_addr_hold got=%h exp=100", mem_Address); end
    cpu_MemWrite = 1'b0;
    pulse_start();
    checks++; if (word_count !== 16'd0 || cycle_count !== 32'd0 || err_overflow !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL mux_reload got=%0d/%0d/%b/%b exp=0/0/0/1", word_count, cycle_count, err_overflow, busy); end
  endtask

  task automatic test_reset_mid_load();
    int base;
    base = wr_total;
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0);
    reset = 1'b0; tick(); reset = 1'b1;
    tick();
    checks++; if (wr_total - base !== 0) begin errors++; $display("FAIL midrst_no_write got=%0d exp=0", wr_total - base); end
    checks++; if (busy !== 1'b0 || cpu_reset !== 1'b1 || word_count !== 16'd0) begin errors++; $display("FAIL midrst_idle got=%b/%b/%0d exp=0/1/0", busy, cpu_reset, word_count); end
    byte_valid = 1'b1; byte_data = 8'h99; #1;
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL midrst_idle_ready got=%b exp=0", byte_ready); end
    tick(); tick(); byte_valid = 1'b0;
    base = wr_total;
    img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
    pulse_start();
    load_bytes(4);
    tick();
    checks++; if (wr_total - base !== 1 || log_addr[base] !== 32'h0 || log_data[base] !== 32'h4433_2211 || log_mask[base] !== 4'hf) begin errors++; $display("FAIL midrst_reload got=%0d/%h/%h/%h exp=1/0/44332211/f", wr_total - base, log_addr[base], log_data[base], log_mask[base]); end
    checks++; if (word_count !== 16'd1) begin errors++; $display("FAIL midrst_word_count got=%0d exp=1", word_count); end
  endtask

  initial begin
    test_reset();
    test_full_load_run();
    test_partial_word();
    test_overflow();
    test_run_mux();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
